rr_arbiter_onehot: RTL

Round-robin arbiter for N requesters with a registered one-hot grant vector. It sits directly upstream of the one-hot-to-binary converter, which consumes gnt to index shared-resource muxes. It also emits a registered binary index (gnt_idx) that the bench cross-checks against the converter output. A grant is held (locked) until the owner acknowledges, then the priority pointer rotates.

---
 rtl/rr_arbiter_onehot.sv | 102 ++++++++++
 1 files changed

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with a registered one-hot grant and binary index.
// The grant is locked until the owner acks; the priority pointer then moves past the owner.
module rr_arbiter_onehot #(
    parameter int W = 4,
    parameter int N = 2**W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state;
    state_t       state_next;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] scan_ptr;
    logic [W-1:0] cand;
    logic [W-1:0] winner;
    logic         found;
    logic [N-1:0] gnt_next;
    logic         valid_next;
    logic [W-1:0] idx_next;

    // On ack the scan starts just past the owner, so handover needs no extra cycle.
    always_comb begin
        scan_ptr = ptr;
        if (state == GRANT && ack) begin
            scan_ptr = gnt_idx + W'(1);
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < N; k++) begin
            cand = scan_ptr + W'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt;
        valid_next = gnt_valid;
        idx_next   = gnt_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_next   = N'(1) << winner;
                    idx_next   = winner;
                    valid_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_next = scan_ptr;
                    if (found) begin
                        gnt_next = N'(1) << winner;
                        idx_next = winner;
                    end else begin
                        // The index keeps its last value while idle.
                        gnt_next   = '0;
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            gnt       <= gnt_next;
            gnt_valid <= valid_next;
            gnt_idx   <= idx_next;
        end
    end

endmodule
